// File: rtl/pipelined_segment_adder.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_segment_adder
//  Purpose  : WIDTH-bit adder/subtractor split into STAGES carry-linked
//             segments, one registered segment per stage, with a
//             valid/ready handshake and backpressure. Bit 1 is the LSB.
//  Ports    : clk, rst_n      - clock, asynchronous active-low reset
//             in_valid/in_ready   - operand beat handshake
//             A, B [WIDTH:1]      - operands
//             cin                 - carry-in (ignored when sub=1)
//             sub                 - 0: S=A+B+cin, 1: S=A-B
//             out_valid/out_ready - result beat handshake
//             S [WIDTH:1]         - sum / difference
//             cout                - carry out of bit WIDTH (sub: 1 = no borrow)
//             ovf                 - two's-complement overflow
//  Revision : 1.0 - initial release
// ============================================================================
module pipelined_segment_adder #(
  parameter int WIDTH  = 27,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:1]   A,
  input  logic [WIDTH:1]   B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:1]   S,
  output logic             cout,
  output logic             ovf
);

  // Segment width; the last segment takes whatever remains.
  localparam int SEG = (WIDTH + STAGES - 1) / STAGES;

  generate
    if (STAGES < 1 || STAGES > WIDTH || (STAGES - 1) * SEG >= WIDTH) begin : g_bad_params
      $error("pipelined_segment_adder: illegal WIDTH/STAGES combination");
    end
  endgenerate

  // Index k of each *_pipe array is the input seen by stage k; index k+1 is
  // what stage k has registered. The s/c/v arrays end at the output register.
  logic [WIDTH:1] a_pipe [STAGES];
  logic [WIDTH:1] b_pipe [STAGES];
  logic [WIDTH:1] s_pipe [STAGES+1];
  logic [STAGES:0] c_pipe;
  logic [STAGES:0] v_pipe;

  // The whole pipeline moves in lockstep: it advances whenever the output
  // register is empty or is being drained this cycle.
  logic w_advance;
  assign w_advance = out_ready | ~out_valid;
  assign in_ready  = w_advance;

  // Subtraction is A + ~B + 1: invert B at entry and force the carry-in.
  assign a_pipe[0] = A;
  assign b_pipe[0] = sub ? ~B : B;
  assign s_pipe[0] = '0;
  assign c_pipe[0] = sub | cin;
  assign v_pipe[0] = in_valid;

  assign S         = s_pipe[STAGES];
  assign cout      = c_pipe[STAGES];
  assign out_valid = v_pipe[STAGES];

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO  = k * SEG + 1;
      localparam int HI  = ((k + 1) * SEG < WIDTH) ? (k + 1) * SEG : WIDTH;
      localparam int LEN = HI - LO + 1;

      logic [LEN:0]   seg_sum_w;
      logic [WIDTH:1] s_d;
      logic [WIDTH:1] s_q;
      logic           c_q;
      logic           v_q;

      // Segment add; bit LEN is the carry handed to the next stage.
      assign seg_sum_w = {1'b0, a_pipe[k][HI:LO]}
                       + {1'b0, b_pipe[k][HI:LO]}
                       + {{LEN{1'b0}}, c_pipe[k]};

      // Lower, already-finished segments ride along unchanged (de-skew).
      always_comb begin
        s_d        = s_pipe[k];
        s_d[HI:LO] = seg_sum_w[LEN-1:0];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          s_q <= '0;
        end else if (w_advance) begin
          v_q <= v_pipe[k];
          c_q <= seg_sum_w[LEN];
          s_q <= s_d;
        end
      end

      assign s_pipe[k+1] = s_q;
      assign c_pipe[k+1] = c_q;
      assign v_pipe[k+1] = v_q;

      if (k < STAGES - 1) begin : g_skew
        // Operand skew registers; gated by the valid bit, so no reset needed.
        logic [WIDTH:1] a_q;
        logic [WIDTH:1] b_q;

        always_ff @(posedge clk) begin
          if (w_advance) begin
            a_q <= a_pipe[k];
            b_q <= b_pipe[k];
          end
        end

        assign a_pipe[k+1] = a_q;
        assign b_pipe[k+1] = b_q;
      end else begin : g_last
        // Carry into the MSB is recovered from the MSB sum bit:
        // c_in = a ^ b ^ s. Overflow is that carry XOR the carry out.
        logic carry_into_msb_w;
        logic ovf_d;
        logic ovf_q;

        assign carry_into_msb_w = a_pipe[k][WIDTH] ^ b_pipe[k][WIDTH] ^ seg_sum_w[LEN-1];
        assign ovf_d            = carry_into_msb_w ^ seg_sum_w[LEN];

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ovf_q <= 1'b0;
          end else if (w_advance) begin
            ovf_q <= ovf_d;
          end
        end

        assign ovf = ovf_q;
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/pipelined_segment_adder.md
Name: pipelined_segment_adder

Overview:
- Parametrised, pipelined successor to the flat 27-bit ripple adder used in the mantissa/accumulate datapath of the GEMM/GEMV units.
- Splits the WIDTH-bit operands into STAGES carry-linked segments, with one registered segment per stage, so long adders close timing at the array clock.
- Adds an add/subtract mode, signed-overflow detection, and a valid/ready handshake with backpressure.
- Sits between the operand-alignment stage and the accumulator register.

Parameters:
- WIDTH, 27, operand/result width; bit range [WIDTH:1], bit 1 is the LSB.
- STAGES, 3, pipeline depth and segment count. Legal range is 1..WIDTH. Elaboration error if (STAGES-1)*SEG >= WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- A  in  WIDTH  operand A, [WIDTH:1].
- B  in  WIDTH  operand B, [WIDTH:1].
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: S=A+B+cin; 1: S=A-B (computed as A+~B+1).
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- S  out  WIDTH  sum/difference, [WIDTH:1].
- cout  out  1  carry out of bit WIDTH. In sub mode, 1 = no borrow (A>=B unsigned).
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Segmentation:
  - SEG = ceil(WIDTH/STAGES).
  - Segment k (0..STAGES-1) covers bits k*SEG+1 .. min((k+1)*SEG, WIDTH); the last segment takes the remainder.
  - WIDTH=27, STAGES=3 gives 9/9/9. WIDTH=8, STAGES=3 gives 3/3/2.
- Stage datapath:
  - Stage k adds segment k using the carry registered by stage k-1. Stage 0 uses cin, or 1 when sub=1.
  - Operand B is inverted at entry when sub=1.
  - Not-yet-consumed upper segments of A and ~B travel in skew registers.
  - Completed lower segments of S travel in de-skew registers, so every segment of one result appears in the same cycle.
- Latency: exactly STAGES cycles from an accepted beat to out_valid, absent stalls. Throughput is 1 beat/cycle.
- Handshake:
  - Global advance = out_ready OR NOT out_valid.
  - in_ready = advance, combinational from out_ready and the output register.
  - Input transfer = in_valid AND in_ready.
  - Output transfer = out_valid AND out_ready.
  - When advance=0, every pipeline register holds and S/cout/ovf/out_valid stay stable.
  - Each stage carries a valid bit. Bubbles advance with the pipeline and may be overwritten while the output is empty. Beat order is always preserved; no beat is dropped or duplicated.
- ovf is computed in the last stage from the carry into bit WIDTH and the carry out of bit WIDTH.
- Reset:
  - rst_n low clears every stage valid bit, out_valid, S, cout and ovf to 0 asynchronously. in_ready then reads 1.
  - Data registers other than the output may be left uncleared; their valid bits gate them.
  - Reset asserted mid-operation discards all in-flight beats. After deassertion, the first out_valid comes STAGES cycles after the first new transfer.
- STAGES=1 degenerates to a single registered adder with latency 1.
- Simultaneous events: in the same cycle, an output transfer and an input transfer both occur and the pipeline shifts by one.
- Changing sub or cin between beats is legal; each beat carries its own mode.

Test Plan:
- Carry through all segments (WIDTH=27, STAGES=3): A=27'h7FFFFFF, B=27'h0000001, cin=0, sub=0, out_ready=1 -> 3 cycles later S=27'h0000000, cout=1, ovf=0, one out_valid pulse.
- Subtract with borrow: A=5, B=7, sub=1 -> S=27'h7FFFFFE, cout=0, ovf=0. Then A=7, B=5 -> S=2, cout=1.
- Signed overflow: A=27'h3FFFFFF, B=1, sub=0 -> S=27'h4000000, ovf=1, cout=0. Also A=27'h4000000, B=1, sub=1 -> S=27'h3FFFFFF, ovf=1.
- Backpressure: stream 6 back-to-back beats, hold out_ready=0 for 4 cycles from the first out_valid -> in_ready=0 and S held during the stall; all 6 results emerge in order with no loss or duplication.
- Reset mid-flight: assert rst_n=0 for 1 cycle with 2 beats in flight -> out_valid=0 immediately and no stale result afterwards. A new beat 1+2 yields S=3 exactly 3 cycles after acceptance.
- Uneven split (WIDTH=8, STAGES=3) and degenerate case (STAGES=1): exhaustive A, B, cin, sub against a reference model with random out_ready -> every S/cout/ovf matches, and latency equals STAGES when not stalled.
